ita_stream_addrgen: RTL and testbench
=====================================

# ita_stream_addrgen

Address generator for one ITA streamer port, directly downstream of the HWPE controller. It latches a 1D/2D access pattern (base, total length, strides, lengths) on a start request and emits one word address per beat on a valid/ready handshake toward the TCDM source/sink. It reports `ready_start`/`done` flags back to the controller FSM. One instance is used per stream: input, weight, bias and output.

## Interface
Parameters:
- `AW`, 32: address width and stride width.
- `CW`, 32: width of the length fields and counters.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `clear_i`  in  1  synchronous soft clear.
- `start_i`  in  1  start request; sampled only in IDLE.
- `base_addr_i`  in  AW  first address.
- `tot_len_i`  in  CW  number of addresses to emit.
- `d0_stride_i`  in  AW  byte step per beat.
- `d0_len_i`  in  CW  beats per d0 row (2D only).
- `d1_stride_i`  in  AW  byte step per d0 wrap (2D only).
- `d1_len_i`  in  CW  rows before the d1 offset wraps (2D only).
- `dim_enable_1h_i`  in  2  `2'b00` = 1D, `2'b01` = 2D; other values are treated as 2D.
- `addr_o`  out  AW  current address; reset value 0.
- `addr_valid_o`  out  1  address valid; reset value 0.
- `addr_ready_i`  in  1  consumer accepts the address.
- `ready_start_o`  out  1  high in IDLE; reset value 1.
- `done_o`  out  1  one-cycle pulse after the last beat; reset value 0.
- `busy_o`  out  1  high when not IDLE; reset value 0.

## Operation
- FSM states: IDLE, RUN.
  - IDLE→RUN on `start_i`. All `*_i` config fields are latched in the same cycle; later input changes are ignored.
  - IDLE→IDLE with a done pulse when `start_i` arrives with `tot_len_i == 0`. No address is emitted.
  - RUN→IDLE on the handshake of beat `tot_len-1`.
- Beat index k, counters d0_cnt and d1_cnt, offsets d0_off and d1_off (all reset to 0 on start).
- `addr_o` = base + d1_off + d0_off, computed modulo 2^AW. Wrap-around is silent.
- On each handshake (`addr_valid_o & addr_ready_i`):
  - 1D: d0_off += d0_stride. There is no row wrap, so `d0_len`, `d1_*` are ignored.
  - 2D, when d0_cnt == d0_len-1: d0_cnt = 0, d0_off = 0, then:
    - if d1_cnt == d1_len-1: d1_cnt = 0 and d1_off = 0 (the pattern repeats);
    - else: d1_cnt++ and d1_off += d1_stride.
  - 2D, otherwise: d0_cnt++ and d0_off += d0_stride.
- A length field of 0 (d0_len or d1_len) is treated as 1.
- `start_i` while busy is ignored. It is neither queued nor counted.
- `clear_i` (priority over everything except reset) forces IDLE, `addr_valid_o` = 0, counters = 0, and no done pulse.
- Asynchronous reset mid-run behaves like clear, with all outputs at their reset values.

## Timing
- Start accepted at cycle t → `addr_valid_o` = 1 at t+1 with `addr_o` = base.
- Throughput is 1 address per cycle while `addr_ready_i` = 1. `addr_o`, `addr_valid_o` and the counters are registered.
- `addr_valid_o` never drops without a handshake. `addr_o` is stable while valid & !ready.
- Last handshake at cycle t_l:
  - `addr_valid_o` = 0 at t_l+1;
  - `done_o` = 1 for exactly cycle t_l+1;
  - `ready_start_o` = 1 and `busy_o` = 0 from t_l+1.
- A new `start_i` during the done cycle is accepted, giving back-to-back jobs with one idle-valid bubble.
- Zero-length start at t → `done_o` at t+1. `addr_valid_o` stays 0.

## Structure
- The `addressgen_ctrl_t` struct (base_addr, tot_len, d0_stride, d0_len, d1_stride, d1_len, d2_stride, dim_enable_1h) and `addressgen_flags_t` (ready_start, done) belong in `ita_hwpe_package`. The top-level wrapper unpacks them onto the flat ports above.
- No sub-module. The FSM, counters and offset accumulators live in one module, with no multipliers (accumulation only).

## Test plan
- 1D, base=0x1000, stride=4, tot_len=4, ready tied 1 → addresses 0x1000, 0x1004, 0x1008, 0x100C on 4 consecutive cycles; done at the following cycle.
- 2D, base=0x0, d0_stride=128, d0_len=2, d1_stride=8, d1_len=2, tot_len=6 → 0x0, 0x80, 0x8, 0x88, 0x0, 0x80 (d1 wrap), then done.
- Backpressure: ready toggled 1-0-0-1 on the 1D case → address held stable across stall cycles; exactly 4 handshakes; done only after the 4th.
- tot_len=0 start → no valid; done pulse at t+1; ready_start stays 1.
- Second start mid-run, then clear_i at beat 2 of a 5-beat job → the second start is ignored; valid low next cycle; no done; idle and ready_start=1; a following job starts from its base.
- Wrap: base=0xFFFF_FFF8, stride=8, tot_len=2 → 0xFFFF_FFF8, then 0x0000_0000.

Source files
------------

// File: rtl/ita_hwpe_package.sv
// rtl/ita_hwpe_package.sv - shared types for the ITA HWPE streamer address generators
package ita_hwpe_package;

    localparam int unsigned ITA_AW = 32;
    localparam int unsigned ITA_CW = 32;

    typedef enum logic {
        AG_IDLE = 1'b0,
        AG_RUN  = 1'b1
    } addressgen_state_e;

    typedef struct packed {
        logic [ITA_AW-1:0] base_addr;
        logic [ITA_CW-1:0] tot_len;
        logic [ITA_AW-1:0] d0_stride;
        logic [ITA_CW-1:0] d0_len;
        logic [ITA_AW-1:0] d1_stride;
        logic [ITA_CW-1:0] d1_len;
        logic [ITA_AW-1:0] d2_stride;
        logic [1:0]        dim_enable_1h;
    } addressgen_ctrl_t;

    typedef struct packed {
        logic ready_start;
        logic done;
    } addressgen_flags_t;

    // Only 2'b00 selects the plain 1D walk; every other encoding runs the 2D pattern.
    function automatic logic dim_is_2d(input logic [1:0] dim_enable_1h);
        return dim_enable_1h != 2'b00;
    endfunction

endpackage

// File: rtl/ita_stream_addrgen.sv
// rtl/ita_stream_addrgen.sv - 1D/2D word address generator for one ITA stream port
module ita_stream_addrgen
    import ita_hwpe_package::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned CW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          start_i,
    input  logic [AW-1:0] base_addr_i,
    input  logic [CW-1:0] tot_len_i,
    input  logic [AW-1:0] d0_stride_i,
    input  logic [CW-1:0] d0_len_i,
    input  logic [AW-1:0] d1_stride_i,
    input  logic [CW-1:0] d1_len_i,
    input  logic [1:0]    dim_enable_1h_i,
    output logic [AW-1:0] addr_o,
    output logic          addr_valid_o,
    input  logic          addr_ready_i,
    output logic          ready_start_o,
    output logic          done_o,
    output logic          busy_o
);

    addressgen_state_e state_q, state_d;

    // Latched job configuration; lengths are kept as "last index" so a zero length behaves as one.
    logic [AW-1:0] base_q, base_d;
    logic [CW-1:0] tot_last_q, tot_last_d;
    logic [AW-1:0] d0_stride_q, d0_stride_d;
    logic [CW-1:0] d0_last_q, d0_last_d;
    logic [AW-1:0] d1_stride_q, d1_stride_d;
    logic [CW-1:0] d1_last_q, d1_last_d;
    logic          two_d_q, two_d_d;

    // Walk state: beat index, per-dimension counters and accumulated offsets.
    logic [CW-1:0] beat_q, beat_d;
    logic [CW-1:0] d0_cnt_q, d0_cnt_d;
    logic [CW-1:0] d1_cnt_q, d1_cnt_d;
    logic [AW-1:0] d0_off_q, d0_off_d;
    logic [AW-1:0] d1_off_q, d1_off_d;

    logic [AW-1:0] addr_q, addr_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;

    logic              handshake;
    addressgen_flags_t flags;

    assign handshake = valid_q & addr_ready_i;

    // Next-state, configuration latch and offset accumulation.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        tot_last_d  = tot_last_q;
        d0_stride_d = d0_stride_q;
        d0_last_d   = d0_last_q;
        d1_stride_d = d1_stride_q;
        d1_last_d   = d1_last_q;
        two_d_d     = two_d_q;
        beat_d      = beat_q;
        d0_cnt_d    = d0_cnt_q;
        d1_cnt_d    = d1_cnt_q;
        d0_off_d    = d0_off_q;
        d1_off_d    = d1_off_q;
        addr_d      = addr_q;
        valid_d     = valid_q;
        done_d      = 1'b0;

        if (clear_i) begin
            state_d  = AG_IDLE;
            valid_d  = 1'b0;
            beat_d   = '0;
            d0_cnt_d = '0;
            d1_cnt_d = '0;
            d0_off_d = '0;
            d1_off_d = '0;
            addr_d   = '0;
        end else begin
            case (state_q)
                AG_IDLE: begin
                    if (start_i) begin
                        base_d      = base_addr_i;
                        tot_last_d  = tot_len_i - 1'b1;
                        d0_stride_d = d0_stride_i;
                        d0_last_d   = (d0_len_i == '0) ? '0 : d0_len_i - 1'b1;
                        d1_stride_d = d1_stride_i;
                        d1_last_d   = (d1_len_i == '0) ? '0 : d1_len_i - 1'b1;
                        two_d_d     = dim_is_2d(dim_enable_1h_i);
                        beat_d      = '0;
                        d0_cnt_d    = '0;
                        d1_cnt_d    = '0;
                        d0_off_d    = '0;
                        d1_off_d    = '0;
                        if (tot_len_i == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = AG_RUN;
                            valid_d = 1'b1;
                            addr_d  = base_addr_i;
                        end
                    end
                end
                AG_RUN: begin
                    if (handshake) begin
                        if (beat_q == tot_last_q) begin
                            state_d = AG_IDLE;
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            beat_d = beat_q + 1'b1;
                            if (!two_d_q) begin
                                d0_off_d = d0_off_q + d0_stride_q;
                            end else if (d0_cnt_q == d0_last_q) begin
                                d0_cnt_d = '0;
                                d0_off_d = '0;
                                if (d1_cnt_q == d1_last_q) begin
                                    d1_cnt_d = '0;
                                    d1_off_d = '0;
                                end else begin
                                    d1_cnt_d = d1_cnt_q + 1'b1;
                                    d1_off_d = d1_off_q + d1_stride_q;
                                end
                            end else begin
                                d0_cnt_d = d0_cnt_q + 1'b1;
                                d0_off_d = d0_off_q + d0_stride_q;
                            end
                            addr_d = base_q + d1_off_d + d0_off_d;
                        end
                    end
                end
                default: begin
                    state_d = AG_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // State, configuration and walk registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= AG_IDLE;
            base_q      <= '0;
            tot_last_q  <= '0;
            d0_stride_q <= '0;
            d0_last_q   <= '0;
            d1_stride_q <= '0;
            d1_last_q   <= '0;
            two_d_q     <= 1'b0;
            beat_q      <= '0;
            d0_cnt_q    <= '0;
            d1_cnt_q    <= '0;
            d0_off_q    <= '0;
            d1_off_q    <= '0;
            addr_q      <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            tot_last_q  <= tot_last_d;
            d0_stride_q <= d0_stride_d;
            d0_last_q   <= d0_last_d;
            d1_stride_q <= d1_stride_d;
            d1_last_q   <= d1_last_d;
            two_d_q     <= two_d_d;
            beat_q      <= beat_d;
            d0_cnt_q    <= d0_cnt_d;
            d1_cnt_q    <= d1_cnt_d;
            d0_off_q    <= d0_off_d;
            d1_off_q    <= d1_off_d;
            addr_q      <= addr_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
        end
    end

    assign flags.ready_start = (state_q == AG_IDLE);
    assign flags.done        = done_q;

    assign addr_o        = addr_q;
    assign addr_valid_o  = valid_q;
    assign ready_start_o = flags.ready_start;
    assign done_o        = flags.done;
    assign busy_o        = (state_q == AG_RUN);

endmodule

// File: tb/tb_ita_stream_addrgen.sv
// tb/tb_ita_stream_addrgen.sv - randomized self-checking bench for ita_stream_addrgen
module tb_ita_stream_addrgen;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        clear_i = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] base_addr_i = '0;
    logic [31:0] tot_len_i = '0;
    logic [31:0] d0_stride_i = '0;
    logic [31:0] d0_len_i = '0;
    logic [31:0] d1_stride_i = '0;
    logic [31:0] d1_len_i = '0;
    logic [1:0]  dim_enable_1h_i = '0;
    logic [31:0] addr_o;
    logic        addr_valid_o;
    logic        addr_ready_i = 1'b1;
    logic        ready_start_o;
    logic        done_o;
    logic        busy_o;

    ita_stream_addrgen #(.AW(32), .CW(32)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
        .base_addr_i(base_addr_i), .tot_len_i(tot_len_i),
        .d0_stride_i(d0_stride_i), .d0_len_i(d0_len_i),
        .d1_stride_i(d1_stride_i), .d1_len_i(d1_len_i),
        .dim_enable_1h_i(dim_enable_1h_i),
        .addr_o(addr_o), .addr_valid_o(addr_valid_o), .addr_ready_i(addr_ready_i),
        .ready_start_o(ready_start_o), .done_o(done_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [31:0] m_list[$];
    logic [31:0] log_q[$];
    logic [31:0] exp_q[$];
    logic        rdy_pat[$];
    bit          m_done = 1'b0;
    bit          rmode = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected address sequence straight from the pattern definition (closed form).
    task automatic build(input logic [31:0] b, input logic [31:0] t, input logic [31:0] s0,
                         input logic [31:0] l0, input logic [31:0] s1, input logic [31:0] l1,
                         input logic [1:0] dm);
        logic [31:0] n0, n1, kk, a;
        n0 = (l0 == 0) ? 32'd1 : l0;
        n1 = (l1 == 0) ? 32'd1 : l1;
        for (int k = 0; k < int'(t); k++) begin
            kk = k;
            if (dm == 2'b00) a = b + kk * s0;
            else             a = b + ((kk / n0) % n1) * s1 + (kk % n0) * s0;
            m_list.push_back(a);
        end
    endtask

    // Compare outputs against the model each cycle, then advance the model on the sampled inputs.
    always @(negedge clk) begin
        if (rst_ni) begin
            chk("valid", {31'b0, addr_valid_o}, {31'b0, m_list.size() != 0});
            if (m_list.size() != 0) chk("addr", addr_o, m_list[0]);
            chk("done", {31'b0, done_o}, {31'b0, m_done});
            chk("ready_start", {31'b0, ready_start_o}, {31'b0, m_list.size() == 0});
            chk("busy", {31'b0, busy_o}, {31'b0, m_list.size() != 0});
            m_done = 1'b0;
            if (clear_i) begin
                m_list.delete();
            end else if (m_list.size() != 0) begin
                if (addr_ready_i) begin
                    log_q.push_back(addr_o);
                    void'(m_list.pop_front());
                    if (m_list.size() == 0) m_done = 1'b1;
                end
            end else if (start_i) begin
                build(base_addr_i, tot_len_i, d0_stride_i, d0_len_i, d1_stride_i, d1_len_i, dim_enable_1h_i);
                if (tot_len_i == 0) m_done = 1'b1;
            end
        end
    end

    // Consumer: scripted pattern first (only while valid), else random or always-ready.
    always begin
        @(posedge clk);
        #1;
        if (rdy_pat.size() != 0 && addr_valid_o) addr_ready_i = rdy_pat.pop_front();
        else if (rmode)                          addr_ready_i = 1'($urandom % 2);
        else                                     addr_ready_i = 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Caller is at posedge+1; start is sampled on the next edge, then inputs are scrambled.
    task automatic launch(input logic [31:0] b, input logic [31:0] t, input logic [31:0] s0,
                          input logic [31:0] l0, input logic [31:0] s1, input logic [31:0] l1,
                          input logic [1:0] dm);
        base_addr_i = b; tot_len_i = t; d0_stride_i = s0; d0_len_i = l0;
        d1_stride_i = s1; d1_len_i = l1; dim_enable_1h_i = dm;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        base_addr_i = $urandom; tot_len_i = $urandom; d0_stride_i = $urandom;
        d0_len_i = $urandom; d1_stride_i = $urandom; d1_len_i = $urandom;
        dim_enable_1h_i = 2'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_list.size() != 0 && n < 2000) begin
            step();
            n++;
        end
        if (n >= 2000) chk("timeout", 32'd1, 32'd0);
        step();
        step();
    endtask

    task automatic chk_log(input string nm);
        chk({nm, "_count"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < log_q.size()) chk(nm, log_q[i], exp_q[i]);
        log_q.delete();
    endtask

    initial begin
        #3;
        chk("rst_addr", addr_o, 32'h0);
        chk("rst_valid", {31'b0, addr_valid_o}, 32'd0);
        chk("rst_ready_start", {31'b0, ready_start_o}, 32'd1);
        chk("rst_done", {31'b0, done_o}, 32'd0);
        chk("rst_busy", {31'b0, busy_o}, 32'd0);
        step();
        rst_ni = 1'b1;
        step();

        launch(32'h1000, 4, 4, 0, 0, 0, 2'b00);
        wait_idle();
        exp_q = {32'h1000, 32'h1004, 32'h1008, 32'h100C};
        chk_log("t1d");

        launch(32'h0, 6, 128, 2, 8, 2, 2'b01);
        wait_idle();
        exp_q = {32'h0, 32'h80, 32'h8, 32'h88, 32'h0, 32'h80};
        chk_log("t2d");

        rdy_pat = {1'b1, 1'b0, 1'b0, 1'b1};
        launch(32'h1000, 4, 4, 0, 0, 0, 2'b00);
        wait_idle();
        exp_q = {32'h1000, 32'h1004, 32'h1008, 32'h100C};
        chk_log("tbp");

        launch(32'h5000, 0, 4, 0, 0, 0, 2'b00);
        wait_idle();
        exp_q.delete();
        chk_log("tzero");

        launch(32'h2000, 5, 4, 0, 0, 0, 2'b00);
        base_addr_i = 32'h9000; tot_len_i = 3; start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        step();
        exp_q = {32'h2000, 32'h2004};
        chk_log("tclr");
        launch(32'h3000, 2, 4, 0, 0, 0, 2'b00);
        wait_idle();
        exp_q = {32'h3000, 32'h3004};
        chk_log("tafter");

        launch(32'hFFFF_FFF8, 2, 8, 0, 0, 0, 2'b00);
        wait_idle();
        exp_q = {32'hFFFF_FFF8, 32'h0};
        chk_log("twrap");

        launch(32'h100, 3, 4, 0, 0, 0, 2'b00);
        begin
            int n = 0;
            while (!done_o && n < 50) begin
                step();
                n++;
            end
            if (n >= 50) chk("b2b_timeout", 32'd1, 32'd0);
        end
        launch(32'h200, 2, 4, 0, 0, 0, 2'b00);
        wait_idle();
        exp_q = {32'h100, 32'h104, 32'h108, 32'h200, 32'h204};
        chk_log("tb2b");

        rmode = 1'b1;
        for (int j = 0; j < 40; j++) begin
            launch($urandom, $urandom_range(0, 20), $urandom_range(0, 64) * 4,
                   $urandom_range(0, 4), $urandom_range(0, 64) * 4, $urandom_range(0, 4),
                   2'($urandom));
            if ($urandom % 4 == 0) begin
                repeat ($urandom_range(0, 5)) step();
                clear_i = 1'b1;
                step();
                clear_i = 1'b0;
            end
            wait_idle();
        end
        log_q.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
